// File: rtl/rx_pkt_reader_if.sv
// rx_pkt_reader_if: descriptor FIFO, packet RAM read port, byte stream and
// statistics bundle. master = reader side, slave = FIFO/RAM/sink side.
interface rx_pkt_reader_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic              desc_dv;
    logic [13:0]       desc;
    logic              desc_ack;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic              buf_rd_en;
    logic [7:0]        buf_rd_data;
    logic [ADDR_W-1:0] rel_ptr;
    logic [7:0]        pkt_data;
    logic              pkt_valid;
    logic              pkt_sof;
    logic              pkt_eof;
    logic              pkt_ready;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        input  desc_dv, desc, buf_rd_data, pkt_ready,
        output desc_ack, buf_rd_addr, buf_rd_en, rel_ptr,
        output pkt_data, pkt_valid, pkt_sof, pkt_eof,
        output pkt_cnt, drop_cnt
    );

    modport slave (
        output desc_dv, desc, buf_rd_data, pkt_ready,
        input  desc_ack, buf_rd_addr, buf_rd_en, rel_ptr,
        input  pkt_data, pkt_valid, pkt_sof, pkt_eof,
        input  pkt_cnt, drop_cnt
    );
endinterface

// File: rtl/rx_pkt_reader.sv
// rx_pkt_reader: pops RX descriptors, streams or drops each frame from the
// circular packet buffer, and returns freed space through rel_ptr.
module rx_pkt_reader #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic            usr_clk,
    input  logic            reset_n,
    rx_pkt_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DROP   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Skid entry layout: {sof, eof, data}.
    localparam int SK_W = 10;

    state_e            state_q, state_d;
    logic [10:0]       len_q, len_d;
    logic [10:0]       iss_q, iss_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rel_ptr_q, rel_ptr_d;
    logic              fl_q, fl_d;
    logic              fl_sof_q, fl_sof_d;
    logic              fl_eof_q, fl_eof_d;
    logic [1:0]        occ_q, occ_d;
    logic [SK_W-1:0]   sk0_q, sk0_d;
    logic [SK_W-1:0]   sk1_q, sk1_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              start;
    logic              drop_now;
    logic              valid;
    logic              pop;
    logic              push;
    logic              last;
    logic              issue;
    logic [1:0]        occ_left;
    logic [ADDR_W-1:0] end_ptr;
    logic [SK_W-1:0]   ret;

    assign start    = (state_q == IDLE) && bus.desc_dv && reset_n;
    assign drop_now = bus.desc[13] || (bus.desc[10:0] == 11'd0);
    assign valid    = (occ_q != 2'd0);
    assign pop      = valid && bus.pkt_ready;
    assign push     = fl_q;
    assign last     = pop && sk0_q[8];
    // A byte leaving this cycle frees its slot for a new read.
    assign occ_left = occ_q - {1'b0, pop};
    assign issue    = (state_q == STREAM) && (iss_q != len_q)
                   && ((occ_left + {1'b0, fl_q}) < 2'd2);
    assign end_ptr  = rd_ptr_q + ADDR_W'(len_q);
    assign ret      = {fl_sof_q, fl_eof_q, bus.buf_rd_data};

    // FSM state register.
    always_ff @(posedge usr_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = drop_now ? DROP : STREAM;
            DROP:    state_d = IDLE;
            STREAM:  if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath outputs.
    always_comb begin
        bus.desc_ack    = start;
        bus.buf_rd_en   = issue;
        bus.buf_rd_addr = rd_ptr_q + ADDR_W'(iss_q);
        bus.rel_ptr     = rel_ptr_q;
        bus.pkt_valid   = valid;
        bus.pkt_data    = valid ? sk0_q[7:0] : 8'd0;
        bus.pkt_sof     = valid && sk0_q[9];
        bus.pkt_eof     = valid && sk0_q[8];
        bus.pkt_cnt     = pkt_cnt_q;
        bus.drop_cnt    = drop_cnt_q;
    end

    // Read issue, skid buffer and pointer/counter updates.
    always_comb begin
        len_d      = len_q;
        iss_d      = iss_q;
        rd_ptr_d   = rd_ptr_q;
        rel_ptr_d  = rel_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fl_d       = issue;
        fl_sof_d   = issue && (iss_q == 11'd0);
        fl_eof_d   = issue && (iss_q == len_q - 11'd1);
        occ_d      = occ_left + {1'b0, push};
        sk0_d      = sk0_q;
        sk1_d      = sk1_q;
        if (start) begin
            len_d = bus.desc[10:0];
            iss_d = 11'd0;
        end
        if (issue) begin
            iss_d = iss_q + 11'd1;
        end
        if (state_q == DROP) begin
            rd_ptr_d   = end_ptr;
            rel_ptr_d  = end_ptr;
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (state_q == DONE) begin
            rd_ptr_d  = end_ptr;
            rel_ptr_d = end_ptr;
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            sk0_d = sk1_q;
        end
        if (push) begin
            if (occ_left == 2'd0) begin
                sk0_d = ret;
            end else begin
                sk1_d = ret;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge usr_clk) begin
        if (!reset_n) begin
            len_q      <= '0;
            iss_q      <= '0;
            rd_ptr_q   <= '0;
            rel_ptr_q  <= '0;
            fl_q       <= 1'b0;
            fl_sof_q   <= 1'b0;
            fl_eof_q   <= 1'b0;
            occ_q      <= '0;
            sk0_q      <= '0;
            sk1_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            len_q      <= len_d;
            iss_q      <= iss_d;
            rd_ptr_q   <= rd_ptr_d;
            rel_ptr_q  <= rel_ptr_d;
            fl_q       <= fl_d;
            fl_sof_q   <= fl_sof_d;
            fl_eof_q   <= fl_eof_d;
            occ_q      <= occ_d;
            sk0_q      <= sk0_d;
            sk1_q      <= sk1_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
